// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand/result handshake bundle for alu_pipe
// master = controller/operand fetch + write-back side, slave = alu_pipe
// in side: in_valid, in_ready, opcode, data, accum, clr_halt
// out side: out_valid, out_ready, alu_out, zero, carry, halted
interface alu_pipe_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] accum;
  logic             clr_halt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic             zero;
  logic             carry;
  logic             halted;
  modport master (
    output in_valid, opcode, data, accum, clr_halt, out_ready,
    input  in_ready, out_valid, alu_out, zero, carry, halted
  );
  modport slave (
    input  in_valid, opcode, data, accum, clr_halt, out_ready,
    output in_ready, out_valid, alu_out, zero, carry, halted
  );
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage handshaked ALU (operand reg S1, result reg S2) with carry flag and halt latch
// ports: clk, rst (async, active-high), bus (alu_pipe_if.slave)
// params: WIDTH operand width, ADDC=1 makes ADD consume the carry flag as carry-in
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter bit ADDC  = 1'b0
) (
  input logic        clk,
  input logic        rst,
  alu_pipe_if.slave  bus
);
  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_ANDD, OP_XORR, OP_LDA, OP_STO, OP_JMP
  } op_t;
  logic             r_s1_valid;
  op_t              r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_acc;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_alu_out;
  logic             r_zero;
  logic             r_carry;
  logic             r_halted;
  logic             w_accept;
  logic             w_s2_load;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  assign w_s2_load    = r_s1_valid & (!r_out_valid | bus.out_ready);
  assign bus.in_ready = !r_halted & (!r_s1_valid | w_s2_load);
  assign w_accept     = bus.in_valid & bus.in_ready;
  // carry is read from the register as it stands when this ADD enters S2,
  // so the previous ADD's carry-out is already there for back-to-back chains
  assign w_cin = ADDC & r_carry;
  assign w_sum = {1'b0, r_data} + {1'b0, r_acc} + {{WIDTH{1'b0}}, w_cin};
  always_comb begin
    w_res = r_op == OP_ADD  ? w_sum[WIDTH-1:0] :
            r_op == OP_ANDD ? r_data & r_acc   :
            r_op == OP_XORR ? r_data ^ r_acc   :
            r_op == OP_LDA  ? r_data           : r_acc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_op        <= OP_HLT;
      r_data      <= '0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_alu_out   <= '0;
      r_zero      <= 1'b0;
      r_carry     <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= op_t'(bus.opcode);
        r_data <= bus.data;
        r_acc  <= bus.accum;
      end
      r_s1_valid <= w_accept | (r_s1_valid & !w_s2_load);
      if (w_s2_load) begin
        r_alu_out <= w_res;
        r_zero    <= r_acc == '0;
        if (r_op == OP_ADD) r_carry <= w_sum[WIDTH];
      end
      r_out_valid <= w_s2_load | (r_out_valid & !bus.out_ready);
      // set has priority over clear
      r_halted <= (w_accept & (bus.opcode == OP_HLT)) | (r_halted & !bus.clr_halt);
    end
  end
  assign bus.out_valid = r_out_valid;
  assign bus.alu_out   = r_alu_out;
  assign bus.zero      = r_zero;
  assign bus.carry     = r_carry;
  assign bus.halted    = r_halted;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench driving an ADDC=0 and an ADDC=1 alu_pipe in lockstep
module tb_alu_pipe;
  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, ANDD = 3'd3,
                         XORR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;
  typedef struct {
    logic [7:0] r0;
    logic [7:0] r1;
    logic       z;
    logic       c0;
    logic       c1;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];
  logic mc0 = 1'b0;
  logic mc1 = 1'b0;
  alu_pipe_if #(.WIDTH(8)) i0 ();
  alu_pipe_if #(.WIDTH(8)) i1 ();
  alu_pipe #(.WIDTH(8), .ADDC(1'b0)) u0 (.clk(clk), .rst(rst), .bus(i0));
  alu_pipe #(.WIDTH(8), .ADDC(1'b1)) u1 (.clk(clk), .rst(rst), .bus(i1));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a, input logic cin);
    logic [8:0] s;
    s = {1'b0, d} + {1'b0, a} + {8'd0, cin};
    return op == ADD  ? s :
           op == ANDD ? {1'b0, d & a} :
           op == XORR ? {1'b0, d ^ a} :
           op == LDA  ? {1'b0, d} : {1'b0, a};
  endfunction
  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] d, input logic [7:0] a);
    i0.in_valid = v; i0.opcode = op; i0.data = d; i0.accum = a;
    i1.in_valid = v; i1.opcode = op; i1.data = d; i1.accum = a;
  endtask
  task automatic set_ready(input logic r);
    i0.out_ready = r;
    i1.out_ready = r;
  endtask
  task automatic set_clr(input logic c);
    i0.clr_halt = c;
    i1.clr_halt = c;
  endtask
  task automatic send(input logic [2:0] op, input logic [7:0] d, input logic [7:0] a);
    drive(1'b1, op, d, a);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (i0.in_ready) break;
    end
    check("accept", {31'd0, i0.in_ready}, 32'd1);
    @(posedge clk);
    #1 drive(1'b0, op, d, a);
  endtask
  task automatic drain();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(posedge clk);
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (i0.out_valid && i0.out_ready) begin
        check("sb_avail", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) begin
          exp_t e;
          e = sb.pop_front();
          check("out0", {24'd0, i0.alu_out}, {24'd0, e.r0});
          check("out1", {24'd0, i1.alu_out}, {24'd0, e.r1});
          check("zero", {31'd0, i0.zero}, {31'd0, e.z});
          check("carry0", {31'd0, i0.carry}, {31'd0, e.c0});
          check("carry1", {31'd0, i1.carry}, {31'd0, e.c1});
          check("valid1", {31'd0, i1.out_valid}, 32'd1);
        end
      end
      if (i0.in_valid && i0.in_ready) begin
        exp_t e;
        logic [8:0] s0, s1;
        s0 = model(i0.opcode, i0.data, i0.accum, 1'b0);
        s1 = model(i0.opcode, i0.data, i0.accum, mc1);
        if (i0.opcode == ADD) begin
          mc0 = s0[8];
          mc1 = s1[8];
        end
        e.r0 = s0[7:0];
        e.r1 = s1[7:0];
        e.z  = i0.accum == 8'd0;
        e.c0 = mc0;
        e.c1 = mc1;
        sb.push_back(e);
      end
    end
  end
  initial begin
    drive(1'b0, HLT, 8'd0, 8'd0);
    set_ready(1'b1);
    set_clr(1'b0);
    #12;
    check("rst_valid", {31'd0, i0.out_valid}, 32'd0);
    check("rst_out", {24'd0, i0.alu_out}, 32'd0);
    check("rst_carry", {31'd0, i1.carry}, 32'd0);
    check("rst_halt", {31'd0, i0.halted}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    check("rdy_after_rst", {31'd0, i0.in_ready}, 32'd1);
    send(ADD, 8'h0F, 8'h01);
    check("lat_n", {31'd0, i0.out_valid}, 32'd0);
    @(posedge clk);
    #1 check("lat_n1", {31'd0, i0.out_valid}, 32'd1);
    send(ADD, 8'hFF, 8'h01);
    send(ADD, 8'h00, 8'h00);
    send(ADD, 8'hFF, 8'h01);
    send(ANDD, 8'hA5, 8'h3C);
    send(XORR, 8'hA5, 8'h3C);
    send(LDA, 8'hA5, 8'h3C);
    send(STO, 8'hA5, 8'h3C);
    send(JMP, 8'hA5, 8'h3C);
    send(SKZ, 8'hA5, 8'h3C);
    send(SKZ, 8'hA5, 8'h00);
    send(ADD, 8'hA5, 8'h3C);
    drain();
    set_ready(1'b0);
    send(ADD, 8'h10, 8'h01);
    send(ADD, 8'h20, 8'h02);
    drive(1'b1, ADD, 8'hF0, 8'h20);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall", {31'd0, i0.in_ready}, 32'd0);
      check("bp_hold", {24'd0, i0.alu_out}, 32'h11);
    end
    @(posedge clk);
    #1 set_ready(1'b1);
    #1 check("bp_rise", {31'd0, i0.in_ready}, 32'd1);
    send(ADD, 8'hF0, 8'h20);
    send(ADD, 8'h40, 8'h04);
    drain();
    send(HLT, 8'h00, 8'h77);
    drive(1'b1, ADD, 8'h01, 8'h01);
    #1 check("halted", {31'd0, i0.halted}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("halt_block", {31'd0, i0.in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 set_clr(1'b1);
    @(posedge clk);
    #1 set_clr(1'b0);
    check("halt_clr", {31'd0, i0.halted}, 32'd0);
    check("halt_rdy", {31'd0, i0.in_ready}, 32'd1);
    send(ADD, 8'h01, 8'h01);
    set_clr(1'b1);
    send(HLT, 8'h12, 8'h34);
    set_clr(1'b0);
    check("halt_set_wins", {31'd0, i0.halted}, 32'd1);
    drain();
    set_clr(1'b1);
    @(posedge clk);
    #1 set_clr(1'b0);
    check("halt_clr2", {31'd0, i0.halted}, 32'd0);
    fork
      begin
        for (int n = 0; n < 30; n++)
          send(3'($urandom_range(1, 7)), 8'($urandom), 8'($urandom_range(0, 3) == 0 ? 0 : $urandom));
      end
      begin
        for (int n = 0; n < 60; n++) begin
          @(posedge clk);
          #1 set_ready(1'($urandom));
        end
        set_ready(1'b1);
      end
    join
    set_ready(1'b1);
    drain();
    set_ready(1'b0);
    send(ADD, 8'hFF, 8'h01);
    send(ADD, 8'h01, 8'h01);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, i0.out_valid}, 32'd0);
    check("arst_out", {24'd0, i0.alu_out}, 32'd0);
    check("arst_zero", {31'd0, i0.zero}, 32'd0);
    check("arst_carry0", {31'd0, i0.carry}, 32'd0);
    check("arst_carry1", {31'd0, i1.carry}, 32'd0);
    check("arst_halt", {31'd0, i1.halted}, 32'd0);
    sb.delete();
    mc0 = 1'b0;
    mc1 = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    set_ready(1'b1);
    check("arst_rdy", {31'd0, i0.in_ready}, 32'd1);
    send(ADD, 8'h0F, 8'h01);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
